// File: rtl/snake_pkg.sv
// Shared definitions for the snake field builder: cell codes, FSM state
// encoding, the empty-count ceiling and a border-ring helper.
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SNAKE = 2'b01,
    CELL_APPLE = 2'b10,
    CELL_BLOCK = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PAINT,
    S_APPLE,
    S_COUNT,
    S_DONE
  } state_t;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // True when (x,y) lies on the outermost ring of a size_x by size_y field.
  function automatic logic on_border(int x, int y, int size_x, int size_y);
    return (x == 0) || (y == 0) || (x == size_x - 1) || (y == size_y - 1);
  endfunction

endpackage

// File: rtl/field_builder_if.sv
// Request/result bundle between a frame producer and the field builder.
// The producer (master) supplies the snake, apple and step request; the
// builder (slave) returns the finished field, empty count and status flags.
interface field_builder_if #(
  parameter int SIZE_X  = 10,
  parameter int SIZE_Y  = 10,
  parameter int COORD_W = 8,
  parameter int MAX_LEN = SIZE_X * SIZE_Y
);

  logic                           step;
  logic [15:0]                    length;
  logic [2*COORD_W*MAX_LEN-1:0]   snake_xy;
  logic [COORD_W-1:0]             apple_x;
  logic [COORD_W-1:0]             apple_y;
  logic                           apple_valid;

  logic [2*SIZE_X*SIZE_Y-1:0]     field;
  logic [15:0]                    empty_cells;
  logic                           busy;
  logic                           done;
  logic                           self_hit;
  logic                           wall_hit;
  logic                           oob;
  logic                           apple_blocked;

  modport master (
    output step, length, snake_xy, apple_x, apple_y, apple_valid,
    input  field, empty_cells, busy, done, self_hit, wall_hit, oob, apple_blocked
  );

  modport slave (
    input  step, length, snake_xy, apple_x, apple_y, apple_valid,
    output field, empty_cells, busy, done, self_hit, wall_hit, oob, apple_blocked
  );

endinterface

// File: rtl/cell_addr.sv
// Converts an (x,y) coordinate into a linear cell index (y*SIZE_X + x) and
// reports whether the coordinate falls inside the field. Out-of-range
// coordinates yield index 0 so callers never address past the field.
module cell_addr #(
  parameter int SIZE_X  = 10,
  parameter int SIZE_Y  = 10,
  parameter int COORD_W = 8,
  parameter int IDX_W   = 7
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [IDX_W-1:0]   index,
  output logic               in_range
);

  // Range check first, then the linear index only for legal coordinates.
  always_comb begin
    in_range = (32'(x) < 32'(SIZE_X)) && (32'(y) < 32'(SIZE_Y));
    index    = in_range ? IDX_W'(32'(y) * 32'(SIZE_X) + 32'(x)) : '0;
  end

endmodule

// File: rtl/field_builder.sv
// Builds one frame of the snake playfield into a private shadow copy:
// clear (optionally with a wall ring), paint the snake one segment per
// cycle, place the apple, count empty cells, then publish everything at
// once with a single-cycle done pulse.
module field_builder
  import snake_pkg::*;
#(
  parameter int SIZE_X  = 10,
  parameter int SIZE_Y  = 10,
  parameter int COORD_W = 8,
  parameter int MAX_LEN = SIZE_X * SIZE_Y,
  parameter int WALLS   = 0
) (
  input  logic          clk,
  input  logic          rst,
  field_builder_if.slave bus
);

  localparam int NCELLS = SIZE_X * SIZE_Y;
  localparam int IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int SEG_W  = 2 * COORD_W;

  // Field contents right after the clear step: all empty, or a block ring.
  function automatic logic [2*NCELLS-1:0] clear_pattern();
    logic [2*NCELLS-1:0] p;
    p = '0;
    for (int yy = 0; yy < SIZE_Y; yy++) begin
      for (int xx = 0; xx < SIZE_X; xx++) begin
        if (WALLS == 1 && on_border(xx, yy, SIZE_X, SIZE_Y)) begin
          p[2*(yy*SIZE_X+xx) +: 2] = CELL_BLOCK;
        end
      end
    end
    return p;
  endfunction

  localparam logic [2*NCELLS-1:0] CLEAR_FIELD = clear_pattern();

  state_t              state;
  logic [15:0]         len_q;
  logic [15:0]         seg_idx;
  logic [15:0]         count;
  logic [COORD_W-1:0]  apple_x_q;
  logic [COORD_W-1:0]  apple_y_q;
  logic                apple_valid_q;
  logic [IDX_W-1:0]    cell_idx;
  logic [2*NCELLS-1:0] shadow;
  logic                self_q, wall_q, oob_q, blocked_q;

  logic [2*NCELLS-1:0] field_q;
  logic [15:0]         empty_q;
  logic                busy_q, done_q;
  logic                self_o, wall_o, oob_o, blocked_o;

  logic [COORD_W-1:0]  seg_x, seg_y;
  logic [IDX_W-1:0]    seg_cell, apple_cell;
  logic                seg_in, apple_in;
  logic [1:0]          seg_val, apple_val, cnt_val;
  logic [15:0]         count_next;
  logic [15:0]         len_clamped;

  // Fetch the current segment, look up cell contents and prepare the next count.
  always_comb begin
    seg_x       = bus.snake_xy[32'(seg_idx)*SEG_W +: COORD_W];
    seg_y       = bus.snake_xy[32'(seg_idx)*SEG_W + COORD_W +: COORD_W];
    seg_val     = shadow[32'(seg_cell)*2 +: 2];
    apple_val   = shadow[32'(apple_cell)*2 +: 2];
    cnt_val     = shadow[32'(cell_idx)*2 +: 2];
    count_next  = (cnt_val == CELL_EMPTY && count != COUNT_MAX) ? count + 16'd1 : count;
    len_clamped = (32'(bus.length) > 32'(MAX_LEN)) ? 16'(MAX_LEN) : bus.length;
  end

  cell_addr #(
    .SIZE_X (SIZE_X),
    .SIZE_Y (SIZE_Y),
    .COORD_W(COORD_W),
    .IDX_W  (IDX_W)
  ) u_seg_addr (
    .x       (seg_x),
    .y       (seg_y),
    .index   (seg_cell),
    .in_range(seg_in)
  );

  cell_addr #(
    .SIZE_X (SIZE_X),
    .SIZE_Y (SIZE_Y),
    .COORD_W(COORD_W),
    .IDX_W  (IDX_W)
  ) u_apple_addr (
    .x       (apple_x_q),
    .y       (apple_y_q),
    .index   (apple_cell),
    .in_range(apple_in)
  );

  // Build sequencer; published outputs only change on the way into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      len_q         <= '0;
      seg_idx       <= '0;
      count         <= '0;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      apple_valid_q <= 1'b0;
      cell_idx      <= '0;
      shadow        <= '0;
      self_q        <= 1'b0;
      wall_q        <= 1'b0;
      oob_q         <= 1'b0;
      blocked_q     <= 1'b0;
      field_q       <= '0;
      empty_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      self_o        <= 1'b0;
      wall_o        <= 1'b0;
      oob_o         <= 1'b0;
      blocked_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.step) begin
            len_q         <= len_clamped;
            apple_x_q     <= bus.apple_x;
            apple_y_q     <= bus.apple_y;
            apple_valid_q <= bus.apple_valid;
            busy_q        <= 1'b1;
            state         <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          shadow    <= CLEAR_FIELD;
          seg_idx   <= '0;
          cell_idx  <= '0;
          count     <= '0;
          self_q    <= 1'b0;
          wall_q    <= 1'b0;
          oob_q     <= 1'b0;
          blocked_q <= 1'b0;
          state     <= (len_q == 16'd0) ? S_APPLE : S_PAINT;
        end
        S_PAINT: begin
          if (!seg_in) begin
            oob_q <= 1'b1;
          end else if (seg_val == CELL_BLOCK) begin
            wall_q <= 1'b1;
          end else if (seg_idx != 16'd0 && seg_val == CELL_SNAKE) begin
            self_q <= 1'b1;
          end else begin
            shadow[32'(seg_cell)*2 +: 2] <= CELL_SNAKE;
          end
          if (seg_idx == len_q - 16'd1) begin
            state <= S_APPLE;
          end else begin
            seg_idx <= seg_idx + 16'd1;
          end
        end
        S_APPLE: begin
          if (apple_valid_q) begin
            if (!apple_in) begin
              oob_q <= 1'b1;
            end else if (apple_val != CELL_EMPTY) begin
              blocked_q <= 1'b1;
            end else begin
              shadow[32'(apple_cell)*2 +: 2] <= CELL_APPLE;
            end
          end
          state <= S_COUNT;
        end
        S_COUNT: begin
          count <= count_next;
          if (cell_idx == IDX_W'(NCELLS - 1)) begin
            field_q   <= shadow;
            empty_q   <= count_next;
            self_o    <= self_q;
            wall_o    <= wall_q;
            oob_o     <= oob_q;
            blocked_o <= blocked_q;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            cell_idx <= cell_idx + 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.field         = field_q;
  assign bus.empty_cells   = empty_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.self_hit      = self_o;
  assign bus.wall_hit      = wall_o;
  assign bus.oob           = oob_o;
  assign bus.apple_blocked = blocked_o;

endmodule
